assoc_array_requester: RTL and testbench

ASSOC_ARRAY_REQUESTER -- requirements
Module: assoc_array_requester

---
 rtl/assoc_array_requester.sv | 207 ++++++++++++++++++++
 tb/tb_assoc_array_requester.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_array_requester.sv
// assoc_array_requester: sequences one outstanding read/write request at a
// time onto a set-associative array with a registered array interface and a
// valid/ready read-response channel.
// Optional flush-all sequencer: define ASSOC_REQ_FLUSH_EN to enable op 10.
module assoc_array_requester #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int NUM_WAY                   = 16,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET) + 1,
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / 8
) (
  input  logic                                         clk_in,
  input  logic                                         reset_n_in,
  input  logic                                         req_valid_in,
  output logic                                         req_ready_out,
  input  logic [1:0]                                   req_op_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             req_set_addr_in,
  input  logic [NUM_WAY-1:0]                           req_way_select_in,
  input  logic [WRITE_MASK_LEN-1:0]                    req_write_mask_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]         req_write_entry_in,
  output logic                                         resp_valid_out,
  input  logic                                         resp_ready_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS*NUM_WAY-1:0] resp_set_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]         resp_entry_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]             resp_set_addr_out,
  output logic                                         array_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]                    array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]             array_set_addr_out,
  output logic [NUM_WAY-1:0]                           array_way_select_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]         array_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS*NUM_WAY-1:0] array_read_set_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]         array_read_single_entry_in,
  output logic                                         busy_out,
  output logic                                         flush_done_out
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
`ifdef ASSOC_REQ_FLUSH_EN
  localparam logic [1:0] OP_FLUSH = 2'b10;
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, FLUSH} state_t;

  state_t                                 state_reg, state_next;
  logic                                   access_en_reg, access_en_next;
  logic [WRITE_MASK_LEN-1:0]              write_en_reg, write_en_next;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       set_addr_reg, set_addr_next;
  logic [NUM_WAY-1:0]                     way_reg, way_next;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   wdata_reg, wdata_next;
  logic                                   is_read_reg, is_read_next;
  logic                                   resp_valid_reg, resp_valid_next;
  logic [SINGLE_ENTRY_SIZE_IN_BITS*NUM_WAY-1:0] resp_set_reg, resp_set_next;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   resp_entry_reg, resp_entry_next;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       resp_set_addr_reg, resp_set_addr_next;
  logic                                   flush_done_reg, flush_done_next;
`ifdef ASSOC_REQ_FLUSH_EN
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       flush_cnt_reg, flush_cnt_next;
`endif

  logic req_accept;

  // A request may only enter while idle and the response slot is free or draining.
  assign req_ready_out = (state_reg == IDLE) && (!resp_valid_reg || resp_ready_in);
  assign req_accept    = req_valid_in && req_ready_out;

  assign busy_out              = (state_reg != IDLE);
  assign flush_done_out        = flush_done_reg;
  assign resp_valid_out        = resp_valid_reg;
  assign resp_set_out          = resp_set_reg;
  assign resp_entry_out        = resp_entry_reg;
  assign resp_set_addr_out     = resp_set_addr_reg;
  assign array_access_en_out   = access_en_reg;
  assign array_write_en_out    = write_en_reg;
  assign array_set_addr_out    = set_addr_reg;
  assign array_way_select_out  = way_reg;
  assign array_write_entry_out = wdata_reg;

  // Next-state and next-output decode; strobes default low so IDLE/CAPTURE never touch the array.
  always_comb begin
    state_next         = state_reg;
    access_en_next     = 1'b0;
    write_en_next      = '0;
    set_addr_next      = set_addr_reg;
    way_next           = way_reg;
    wdata_next         = wdata_reg;
    is_read_next       = is_read_reg;
    resp_valid_next    = resp_valid_reg && !resp_ready_in;
    resp_set_next      = resp_set_reg;
    resp_entry_next    = resp_entry_reg;
    resp_set_addr_next = resp_set_addr_reg;
    flush_done_next    = 1'b0;
`ifdef ASSOC_REQ_FLUSH_EN
    flush_cnt_next     = flush_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_accept) begin
          case (req_op_in)
            OP_READ: begin
              access_en_next = 1'b1;
              set_addr_next  = req_set_addr_in;
              way_next       = req_way_select_in;
              is_read_next   = 1'b1;
              state_next     = ACCESS;
            end
            OP_WRITE: begin
              access_en_next = 1'b1;
              write_en_next  = req_write_mask_in;
              set_addr_next  = req_set_addr_in;
              way_next       = req_way_select_in;
              wdata_next     = req_write_entry_in;
              is_read_next   = 1'b0;
              state_next     = ACCESS;
            end
`ifdef ASSOC_REQ_FLUSH_EN
            OP_FLUSH: begin
              access_en_next = 1'b1;
              write_en_next  = '1;
              set_addr_next  = '0;
              way_next       = '1;
              wdata_next     = '0;
              flush_cnt_next = '0;
              state_next     = FLUSH;
            end
`endif
            default: ;  // reserved op: accepted and dropped
          endcase
        end
      end
      ACCESS: begin
        // Writes finish after their single strobe cycle; reads wait for array data.
        state_next = is_read_reg ? CAPTURE : IDLE;
      end
      CAPTURE: begin
        resp_valid_next    = 1'b1;
        resp_set_next      = array_read_set_in;
        resp_entry_next    = array_read_single_entry_in;
        resp_set_addr_next = set_addr_reg;
        state_next         = IDLE;
      end
      FLUSH: begin
`ifdef ASSOC_REQ_FLUSH_EN
        if (flush_cnt_reg == LAST_SET) begin
          flush_done_next = 1'b1;
          state_next      = IDLE;
        end else begin
          flush_cnt_next = flush_cnt_reg + SET_PTR_WIDTH_IN_BITS'(1);
          access_en_next = 1'b1;
          write_en_next  = '1;
          set_addr_next  = flush_cnt_reg + SET_PTR_WIDTH_IN_BITS'(1);
          way_next       = '1;
          wdata_next     = '0;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  // Registered array strobes and response holding registers.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      access_en_reg     <= 1'b0;
      write_en_reg      <= '0;
      set_addr_reg      <= '0;
      way_reg           <= '0;
      wdata_reg         <= '0;
      is_read_reg       <= 1'b0;
      resp_valid_reg    <= 1'b0;
      resp_set_reg      <= '0;
      resp_entry_reg    <= '0;
      resp_set_addr_reg <= '0;
      flush_done_reg    <= 1'b0;
    end else begin
      access_en_reg     <= access_en_next;
      write_en_reg      <= write_en_next;
      set_addr_reg      <= set_addr_next;
      way_reg           <= way_next;
      wdata_reg         <= wdata_next;
      is_read_reg       <= is_read_next;
      resp_valid_reg    <= resp_valid_next;
      resp_set_reg      <= resp_set_next;
      resp_entry_reg    <= resp_entry_next;
      resp_set_addr_reg <= resp_set_addr_next;
      flush_done_reg    <= flush_done_next;
    end
  end

`ifdef ASSOC_REQ_FLUSH_EN
  // Flush set counter; saturates at the last set rather than wrapping.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) flush_cnt_reg <= '0;
    else             flush_cnt_reg <= flush_cnt_next;
  end
`endif

endmodule

// File: tb/tb_assoc_array_requester.sv
// Testbench for assoc_array_requester: directed scenarios plus randomized
// read/write/no-op traffic checked against a set/way content model.
module tb_assoc_array_requester;

  localparam int EW = 64;
  localparam int NS = 64;
  localparam int NW = 16;
  localparam int AW = 7;
  localparam int MW = 8;

  logic               clk_in = 1'b0;
  logic               reset_n_in;
  logic               req_valid_in;
  logic               req_ready_out;
  logic [1:0]         req_op_in;
  logic [AW-1:0]      req_set_addr_in;
  logic [NW-1:0]      req_way_select_in;
  logic [MW-1:0]      req_write_mask_in;
  logic [EW-1:0]      req_write_entry_in;
  logic               resp_valid_out;
  logic               resp_ready_in;
  logic [EW*NW-1:0]   resp_set_out;
  logic [EW-1:0]      resp_entry_out;
  logic [AW-1:0]      resp_set_addr_out;
  logic               array_access_en_out;
  logic [MW-1:0]      array_write_en_out;
  logic [AW-1:0]      array_set_addr_out;
  logic [NW-1:0]      array_way_select_out;
  logic [EW-1:0]      array_write_entry_out;
  logic [EW*NW-1:0]   array_read_set_in;
  logic [EW-1:0]      array_read_single_entry_in;
  logic               busy_out;
  logic               flush_done_out;

  assoc_array_requester #(
    .SINGLE_ENTRY_SIZE_IN_BITS(EW), .NUM_SET(NS), .NUM_WAY(NW),
    .SET_PTR_WIDTH_IN_BITS(AW), .WRITE_MASK_LEN(MW)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_op_in(req_op_in),
    .req_set_addr_in(req_set_addr_in), .req_way_select_in(req_way_select_in),
    .req_write_mask_in(req_write_mask_in), .req_write_entry_in(req_write_entry_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_set_out(resp_set_out), .resp_entry_out(resp_entry_out), .resp_set_addr_out(resp_set_addr_out),
    .array_access_en_out(array_access_en_out), .array_write_en_out(array_write_en_out),
    .array_set_addr_out(array_set_addr_out), .array_way_select_out(array_way_select_out),
    .array_write_entry_out(array_write_entry_out),
    .array_read_set_in(array_read_set_in), .array_read_single_entry_in(array_read_single_entry_in),
    .busy_out(busy_out), .flush_done_out(flush_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Array contents as the DUT leaves them (mem) and as the requests say they should be (exp_mem).
  logic [EW-1:0] mem     [NS][NW];
  logic [EW-1:0] exp_mem [NS][NW];
  logic [AW-1:0] strobe_q [$];
  int cyc = 0;
  int last_strobe_cyc = 0;
  int flush_like_cnt = 0;
  bit mem_ready = 1'b0;
  int errors = 0;
  int checks = 0;

  function automatic logic [EW-1:0] init_val(input int s, input int w);
    return {16'hC0DE, 8'(s), 8'(w), 32'(s * 131 + w * 7919)};
  endfunction

  function automatic logic [EW*NW-1:0] exp_row(input int s);
    logic [EW*NW-1:0] r;
    for (int w = 0; w < NW; w++) r[w*EW +: EW] = exp_mem[s][w];
    return r;
  endfunction

  // Behavioural array: one-cycle read latency, byte-masked multi-way writes; logs every strobe.
  always @(posedge clk_in) begin : array_model
    logic [EW*NW-1:0] rd_set;
    logic [EW-1:0]    rd_one;
    int a;
    if (!mem_ready) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++) mem[s][w] = init_val(s, w);
      mem_ready = 1'b1;
    end
    cyc++;
    if (array_access_en_out) begin
      strobe_q.push_back(array_set_addr_out);
      last_strobe_cyc = cyc;
      if (array_write_en_out == '1 && array_way_select_out == '1 && array_write_entry_out == '0)
        flush_like_cnt++;
      a = int'(array_set_addr_out);
      if (a < NS) begin
        if (array_write_en_out == '0) begin
          rd_set = '0;
          rd_one = '0;
          for (int w = 0; w < NW; w++) begin
            rd_set[w*EW +: EW] = mem[a][w];
            if (array_way_select_out[w]) rd_one = mem[a][w];
          end
          array_read_set_in          <= rd_set;
          array_read_single_entry_in <= rd_one;
        end else begin
          for (int w = 0; w < NW; w++)
            for (int b = 0; b < MW; b++)
              if (array_way_select_out[w] && array_write_en_out[b])
                mem[a][w][b*8 +: 8] = array_write_entry_out[b*8 +: 8];
        end
      end
    end
  end

  // Reference effect of a write request on the array contents.
  task automatic wr_model(input int s, input logic [NW-1:0] way, input logic [MW-1:0] mask, input logic [EW-1:0] data);
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < MW; b++)
        if (way[w] && mask[b]) exp_mem[s][w][b*8 +: 8] = data[b*8 +: 8];
  endtask

  // Present a request and hold it until accepted; returns at E0 + 1.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] s, input logic [NW-1:0] way,
                       input logic [MW-1:0] mask, input logic [EW-1:0] data);
    int n;
    @(negedge clk_in);
    req_valid_in = 1'b1; req_op_in = op; req_set_addr_in = s;
    req_way_select_in = way; req_write_mask_in = mask; req_write_entry_in = data;
    #1;
    n = 0;
    while (!req_ready_out && n < 50) begin
      @(negedge clk_in); #1; n++;
    end
    checks++;
    if (req_ready_out !== 1'b1) begin
      errors++; $display("FAIL issue_ready_timeout op=%0d got ready=%b exp=1", op, req_ready_out);
    end
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
      checks++; if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid_out); end
      checks++; if (flush_done_out !== 1'b0) begin errors++; $display("FAIL reset_flush_done got=%b exp=0", flush_done_out); end
      checks++;
      if ({array_access_en_out, array_write_en_out, array_set_addr_out, array_way_select_out, array_write_entry_out} !== '0) begin
        errors++; $display("FAIL reset_array_outputs got en=%b we=%h addr=%0d way=%h exp=all zero",
                           array_access_en_out, array_write_en_out, array_set_addr_out, array_way_select_out);
      end
      checks++;
      if ({resp_set_out, resp_entry_out, resp_set_addr_out} !== '0) begin
        errors++; $display("FAIL reset_resp_data got entry=%h addr=%0d exp=0", resp_entry_out, resp_set_addr_out);
      end
      checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_out); end
      repeat (2) @(posedge clk_in);
    end
    @(negedge clk_in); reset_n_in = 1'b1;
    @(negedge clk_in);
    $display("txn reset released");
  endtask

  task automatic test_read();
    int s0;
    resp_ready_in = 1'b1;
    issue(2'b01, 7'd5, 16'h0004, 8'hFF, 64'hDEAD);
    wr_model(5, 16'h0004, 8'hFF, 64'hDEAD);
    @(posedge clk_in); #1;
    s0 = strobe_q.size();
    issue(2'b00, 7'd5, 16'h0004, 8'h00, 64'h0);
    checks++;
    if (array_access_en_out !== 1'b1 || array_write_en_out !== 8'h00 || array_set_addr_out !== 7'd5 || array_way_select_out !== 16'h0004) begin
      errors++; $display("FAIL read_strobe got en=%b we=%h addr=%0d way=%h exp en=1 we=00 addr=5 way=0004",
                         array_access_en_out, array_write_en_out, array_set_addr_out, array_way_select_out);
    end
    checks++; if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b0) begin errors++; $display("FAIL read_e0_state got valid=%b ready=%b exp 0/0", resp_valid_out, req_ready_out); end
    @(posedge clk_in); #1;
    checks++; if (array_access_en_out !== 1'b0 || resp_valid_out !== 1'b0) begin errors++; $display("FAIL read_e1 got en=%b valid=%b exp 0/0", array_access_en_out, resp_valid_out); end
    @(posedge clk_in); #1;
    checks++; if (resp_valid_out !== 1'b1) begin errors++; $display("FAIL read_e2_valid got=%b exp=1", resp_valid_out); end
    checks++; if (resp_entry_out !== 64'hDEAD) begin errors++; $display("FAIL read_entry got=%h exp=%h", resp_entry_out, 64'hDEAD); end
    checks++; if (resp_set_addr_out !== 7'd5) begin errors++; $display("FAIL read_set_addr got=%0d exp=5", resp_set_addr_out); end
    checks++; if (resp_set_out !== exp_row(5)) begin errors++; $display("FAIL read_set_row got way2=%h exp way2=%h", resp_set_out[2*EW +: EW], exp_mem[5][2]); end
    checks++; if (strobe_q.size() - s0 != 1) begin errors++; $display("FAIL read_strobe_count got=%0d exp=1", strobe_q.size() - s0); end
    @(posedge clk_in); #1;
    checks++; if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL read_handshake_clear got=%b exp=0", resp_valid_out); end
    $display("txn read set=5 way=0004 entry=%h", resp_entry_out);
  endtask

  task automatic test_write();
    logic [EW-1:0] d;
    int s0;
    int seen;
    d = {$urandom, $urandom};
    s0 = strobe_q.size();
    issue(2'b01, 7'd3, 16'h0100, 8'h0F, d);
    wr_model(3, 16'h0100, 8'h0F, d);
    checks++;
    if (array_access_en_out !== 1'b1 || array_write_en_out !== 8'h0F || array_set_addr_out !== 7'd3 ||
        array_way_select_out !== 16'h0100 || array_write_entry_out !== d) begin
      errors++; $display("FAIL write_strobe got en=%b we=%h addr=%0d way=%h data=%h exp en=1 we=0f addr=3 way=0100 data=%h",
                         array_access_en_out, array_write_en_out, array_set_addr_out, array_way_select_out, array_write_entry_out, d);
    end
    @(posedge clk_in); #1;
    checks++; if (array_access_en_out !== 1'b0 || array_write_en_out !== 8'h00) begin errors++; $display("FAIL write_e1_strobe got en=%b we=%h exp 0/00", array_access_en_out, array_write_en_out); end
    checks++; if (req_ready_out !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL write_e1_ready got ready=%b busy=%b exp 1/0", req_ready_out, busy_out); end
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (resp_valid_out) seen++;
      @(posedge clk_in); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL write_no_resp got valid cycles=%0d exp=0", seen); end
    checks++; if (strobe_q.size() - s0 != 1) begin errors++; $display("FAIL write_strobe_count got=%0d exp=1", strobe_q.size() - s0); end
    checks++; if (mem[3][8] !== exp_mem[3][8]) begin errors++; $display("FAIL write_array_content got=%h exp=%h", mem[3][8], exp_mem[3][8]); end
    $display("txn write set=3 way=0100 mask=0f data=%h", d);
  endtask

  task automatic test_back_to_back();
    logic [EW*NW-1:0] snap_set;
    logic [EW-1:0]    snap_e;
    logic [AW-1:0]    snap_a;
    int bad;
    resp_ready_in = 1'b0;
    issue(2'b00, 7'd9, 16'h0080, 8'h00, 64'h0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    checks++; if (resp_valid_out !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got=%b exp=1", resp_valid_out); end
    checks++; if (resp_entry_out !== exp_mem[9][7]) begin errors++; $display("FAIL b2b_first_entry got=%h exp=%h", resp_entry_out, exp_mem[9][7]); end
    snap_set = resp_set_out; snap_e = resp_entry_out; snap_a = resp_set_addr_out;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      if (resp_valid_out !== 1'b1 || resp_entry_out !== snap_e || resp_set_out !== snap_set ||
          resp_set_addr_out !== snap_a || req_ready_out !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_stall_stable got unstable cycles=%0d exp=0", bad); end
    @(negedge clk_in);
    resp_ready_in = 1'b1;
    req_valid_in = 1'b1; req_op_in = 2'b00; req_set_addr_in = 7'd33; req_way_select_in = 16'h8000;
    #1;
    checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready_on_release got=%b exp=1", req_ready_out); end
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
    checks++; if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_handshake_clear got=%b exp=0", resp_valid_out); end
    checks++; if (array_access_en_out !== 1'b1 || array_set_addr_out !== 7'd33) begin errors++; $display("FAIL b2b_second_strobe got en=%b addr=%0d exp 1/33", array_access_en_out, array_set_addr_out); end
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    checks++;
    if (resp_valid_out !== 1'b1 || resp_entry_out !== exp_mem[33][15] || resp_set_addr_out !== 7'd33) begin
      errors++; $display("FAIL b2b_second_resp got valid=%b entry=%h addr=%0d exp 1/%h/33", resp_valid_out, resp_entry_out, resp_set_addr_out, exp_mem[33][15]);
    end
    @(posedge clk_in); #1;
    $display("txn back_to_back set=9 then set=33");
  endtask

  task automatic test_reset_mid_read();
    int seen;
    resp_ready_in = 1'b1;
    issue(2'b00, 7'd12, 16'h0002, 8'h00, 64'h0);
    reset_n_in = 1'b0;
    #1;
    checks++;
    if (array_access_en_out !== 1'b0 || busy_out !== 1'b0 || array_set_addr_out !== '0 || array_way_select_out !== '0) begin
      errors++; $display("FAIL midread_reset_async got en=%b busy=%b addr=%0d way=%h exp all 0",
                         array_access_en_out, busy_out, array_set_addr_out, array_way_select_out);
    end
    @(negedge clk_in); reset_n_in = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_in); #1;
      if (resp_valid_out !== 1'b0 || busy_out !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midread_reset_no_resp got bad cycles=%0d exp=0", seen); end
    $display("txn read aborted by reset");
  endtask

`ifdef ASSOC_REQ_FLUSH_EN
  task automatic test_flush();
    int s0, f0, pulses, ready_bad, order_bad;
    bit done_ok;
    s0 = strobe_q.size(); f0 = flush_like_cnt;
    pulses = 0; ready_bad = 0; done_ok = 1'b0; order_bad = 0;
    issue(2'b10, 7'd0, 16'h0, 8'h00, 64'h0);
    checks++; if (busy_out !== 1'b1 || req_ready_out !== 1'b0 || array_access_en_out !== 1'b1 || array_set_addr_out !== 7'd0) begin
      errors++; $display("FAIL flush_start got busy=%b ready=%b en=%b addr=%0d exp 1/0/1/0", busy_out, req_ready_out, array_access_en_out, array_set_addr_out);
    end
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_in); #1;
      if (flush_done_out) begin pulses++; done_ok = (cyc == last_strobe_cyc); end
      if (busy_out && req_ready_out) ready_bad++;
    end
    checks++; if (strobe_q.size() - s0 != NS) begin errors++; $display("FAIL flush_strobe_count got=%0d exp=%0d", strobe_q.size() - s0, NS); end
    for (int k = 0; k < NS && s0 + k < strobe_q.size(); k++) if (strobe_q[s0 + k] != AW'(k)) order_bad++;
    checks++; if (order_bad != 0) begin errors++; $display("FAIL flush_addr_order got out-of-order=%0d exp=0", order_bad); end
    checks++; if (flush_like_cnt - f0 != NS) begin errors++; $display("FAIL flush_pattern got zero-data all-ones strobes=%0d exp=%0d", flush_like_cnt - f0, NS); end
    checks++; if (pulses != 1 || !done_ok) begin errors++; $display("FAIL flush_done_pulse got pulses=%0d timing_ok=%0d exp 1/1", pulses, done_ok); end
    checks++; if (ready_bad != 0 || busy_out !== 1'b0) begin errors++; $display("FAIL flush_ready_busy got ready_while_busy=%0d busy=%b exp 0/0", ready_bad, busy_out); end
    for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) exp_mem[s][w] = '0;
    $display("txn flush strobes=%0d done_pulses=%0d", strobe_q.size() - s0, pulses);
  endtask

  task automatic test_flush_reset();
    int s0, n, pulses, bad;
    s0 = strobe_q.size();
    issue(2'b10, 7'd0, 16'h0, 8'h00, 64'h0);
    n = 0;
    while (!(array_access_en_out && array_set_addr_out == 7'd20) && n < 100) begin
      @(posedge clk_in); #1; n++;
    end
    checks++; if (array_set_addr_out !== 7'd20) begin errors++; $display("FAIL flushrst_reach_20 got addr=%0d exp=20", array_set_addr_out); end
    reset_n_in = 1'b0;
    #1;
    checks++;
    if ({array_access_en_out, array_write_en_out, array_set_addr_out, array_way_select_out, busy_out, flush_done_out, resp_valid_out} !== '0) begin
      errors++; $display("FAIL flushrst_async got en=%b we=%h addr=%0d way=%h busy=%b exp all 0",
                         array_access_en_out, array_write_en_out, array_set_addr_out, array_way_select_out, busy_out);
    end
    @(negedge clk_in); reset_n_in = 1'b1;
    pulses = 0; bad = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk_in); #1;
      if (flush_done_out) pulses++;
      if (busy_out) bad++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL flushrst_no_done got pulses=%0d exp=0", pulses); end
    checks++; if (bad != 0 || req_ready_out !== 1'b1) begin errors++; $display("FAIL flushrst_idle got busy cycles=%0d ready=%b exp 0/1", bad, req_ready_out); end
    checks++; if (strobe_q.size() - s0 != 20) begin errors++; $display("FAIL flushrst_strobes got=%0d exp=20", strobe_q.size() - s0); end
    for (int s = 0; s < 20; s++) for (int w = 0; w < NW; w++) exp_mem[s][w] = '0;
    $display("txn flush aborted at set 20");
  endtask
`else
  task automatic test_flush_disabled();
    int s0, bad;
    s0 = strobe_q.size();
    issue(2'b10, 7'd0, 16'h0, 8'h00, 64'h0);
    checks++; if (busy_out !== 1'b0 || array_access_en_out !== 1'b0 || req_ready_out !== 1'b1) begin
      errors++; $display("FAIL flushoff_noop got busy=%b en=%b ready=%b exp 0/0/1", busy_out, array_access_en_out, req_ready_out);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      if (resp_valid_out || flush_done_out || busy_out) bad++;
    end
    checks++; if (bad != 0 || strobe_q.size() != s0) begin errors++; $display("FAIL flushoff_quiet got bad cycles=%0d strobes=%0d exp 0/0", bad, strobe_q.size() - s0); end
    $display("txn op10 treated as no-op");
  endtask
`endif

  task automatic test_random();
    logic [1:0] op;
    logic [NW-1:0] way;
    logic [MW-1:0] mask;
    logic [EW-1:0] data;
    logic [EW-1:0] snap_e;
    int s, wi, r, hold, s0, bad, exp_strobes;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = 2'b00;
      else if (r < 8) op = 2'b01;
`ifdef ASSOC_REQ_FLUSH_EN
      else op = 2'b11;
`else
      else op = (r == 8) ? 2'b11 : 2'b10;
`endif
      s = $urandom_range(0, NS - 1);
      wi = $urandom_range(0, NW - 1);
      way = '0; way[wi] = 1'b1;
      mask = MW'($urandom);
      data = {$urandom, $urandom};
      s0 = strobe_q.size();
      issue(op, AW'(s), way, mask, data);
      if (op == 2'b00) begin
        hold = $urandom_range(0, 3);
        resp_ready_in = (hold == 0);
        @(posedge clk_in); #1;
        checks++; if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL rnd_early_valid txn=%0d got=%b exp=0", i, resp_valid_out); end
        @(posedge clk_in); #1;
        checks++;
        if (resp_valid_out !== 1'b1 || resp_entry_out !== exp_mem[s][wi] || resp_set_addr_out !== AW'(s) || resp_set_out !== exp_row(s)) begin
          errors++; $display("FAIL rnd_read txn=%0d set=%0d way=%0d got valid=%b entry=%h addr=%0d exp 1/%h/%0d",
                             i, s, wi, resp_valid_out, resp_entry_out, resp_set_addr_out, exp_mem[s][wi], s);
        end
        snap_e = resp_entry_out;
        bad = 0;
        for (int k = 0; k < hold; k++) begin
          @(posedge clk_in); #1;
          if (resp_valid_out !== 1'b1 || resp_entry_out !== snap_e) bad++;
        end
        resp_ready_in = 1'b1;
        @(posedge clk_in); #1;
        checks++; if (bad != 0 || resp_valid_out !== 1'b0) begin errors++; $display("FAIL rnd_hold txn=%0d got unstable=%0d valid_after=%b exp 0/0", i, bad, resp_valid_out); end
      end else begin
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        checks++; if (resp_valid_out !== 1'b0 || busy_out !== 1'b0) begin errors++; $display("FAIL rnd_no_resp txn=%0d op=%0d got valid=%b busy=%b exp 0/0", i, op, resp_valid_out, busy_out); end
      end
      if (op == 2'b01) wr_model(s, way, mask, data);
      exp_strobes = (op == 2'b00 || op == 2'b01) ? 1 : 0;
      checks++; if (strobe_q.size() - s0 != exp_strobes) begin errors++; $display("FAIL rnd_strobes txn=%0d op=%0d got=%0d exp=%0d", i, op, strobe_q.size() - s0, exp_strobes); end
      $display("txn %0d op=%0d set=%0d way=%0d mask=%h data=%h", i, op, s, wi, mask, data);
    end
    bad = 0;
    for (int a = 0; a < NS; a++) for (int w = 0; w < NW; w++) if (mem[a][w] !== exp_mem[a][w]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_array_contents got mismatched entries=%0d exp=0", bad); end
  endtask

  initial begin
    reset_n_in = 1'b0;
    req_valid_in = 1'b0; req_op_in = 2'b00; req_set_addr_in = '0; req_way_select_in = '0;
    req_write_mask_in = '0; req_write_entry_in = '0; resp_ready_in = 1'b1;
    for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) exp_mem[s][w] = init_val(s, w);
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_read();
`ifdef ASSOC_REQ_FLUSH_EN
    test_flush();
    test_flush_reset();
`else
    test_flush_disabled();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
